// File: rtl/comparator_2b_bist.sv
// -----------------------------------------------------------------------------
// comparator_2b_bist
//
// Built-in self-test sequencer for a WIDTH-bit magnitude comparator. It walks
// every (A,B) operand pair in A-major order, holds each pair for SETTLE_CYCLES
// cycles, then samples the comparator's three flags for one cycle. Each sampled
// flag triple is compared with the expected {A>B, A==B, A<B}, and failing
// vectors are counted.
//
// Optional feature (compile-time macro BIST_FIRST_FAIL_EN):
//   When defined, the operands and observed flags of the first failing vector
//   of a sweep are captured on fail_a / fail_b / fail_flags.
//
// Parameters
//   WIDTH          operand width; a sweep covers 2**(2*WIDTH) vectors
//   SETTLE_CYCLES  cycles each operand pair is held before sampling (>= 1)
//
// Ports
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   begin a sweep (only honoured while idle or done)
//   A_out       out  operand A to the comparator (registered)
//   B_out       out  operand B to the comparator (registered)
//   A_great_B   in   comparator flag under test
//   A_equal_B   in   comparator flag under test
//   A_less_B    in   comparator flag under test
//   busy        out  sweep in progress
//   done        out  sweep complete, held until the next accepted start
//   pass        out  valid while done=1; 1 when no vector failed
//   err_count   out  number of failing vectors, saturating
//   fail_a      out  (BIST_FIRST_FAIL_EN) operand A of first failing vector
//   fail_b      out  (BIST_FIRST_FAIL_EN) operand B of first failing vector
//   fail_flags  out  (BIST_FIRST_FAIL_EN) observed {gt,eq,lt} of that vector
// -----------------------------------------------------------------------------
module comparator_2b_bist #(
    parameter int WIDTH         = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [WIDTH-1:0]   A_out,
    output logic [WIDTH-1:0]   B_out,
    input  logic               A_great_B,
    input  logic               A_equal_B,
    input  logic               A_less_B,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count
`ifdef BIST_FIRST_FAIL_EN
    ,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b,
    output logic [2:0]         fail_flags
`endif
);

    localparam int IW = 2 * WIDTH;
    localparam int EW = 2 * WIDTH + 1;
    // Counter only has to hold SETTLE_CYCLES-1.
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [IW-1:0] INDEX_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [IW-1:0]     index_reg;
    logic [IW-1:0]     index_inc;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [CW-1:0]     settle_cnt_reg;
    logic [EW-1:0]     err_count_reg;
    logic              accept;
    logic              vec_fail;
    logic [2:0]        observed;
    logic [2:0]        expected;

    assign accept    = ((state_reg == IDLE) || (state_reg == DONE)) && start;
    assign index_inc = index_reg + IW'(1);
    assign observed  = {A_great_B, A_equal_B, A_less_B};
    assign expected  = {a_reg > b_reg, a_reg == b_reg, a_reg < b_reg};
    // A non-one-hot flag triple can never equal the one-hot expectation, so
    // this single compare also catches one-hot violations.
    assign vec_fail  = (observed != expected);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: if (start) state_next = SETTLE;
            SETTLE:     if (settle_cnt_reg == '0) state_next = CHECK;
            CHECK:      state_next = (index_reg == INDEX_MAX) ? DONE : SETTLE;
            default:    state_next = IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        busy = (state_reg == SETTLE) || (state_reg == CHECK);
        done = (state_reg == DONE);
        // err_count is already final once DONE is entered.
        pass = (state_reg == DONE) && (err_count_reg == '0);
    end

    assign A_out     = a_reg;
    assign B_out     = b_reg;
    assign err_count = err_count_reg;

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_reg      <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            settle_cnt_reg <= '0;
            err_count_reg  <= '0;
        end else if (accept) begin
            index_reg      <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            settle_cnt_reg <= SETTLE_LOAD;
            err_count_reg  <= '0;
        end else begin
            case (state_reg)
                SETTLE: begin
                    if (settle_cnt_reg != '0) begin
                        settle_cnt_reg <= settle_cnt_reg - CW'(1);
                    end
                end
                CHECK: begin
                    if (vec_fail && (err_count_reg != '1)) begin
                        err_count_reg <= err_count_reg + EW'(1);
                    end
                    // Index stops at max; the sweep ends instead of wrapping.
                    if (index_reg != INDEX_MAX) begin
                        index_reg      <= index_inc;
                        a_reg          <= index_inc[IW-1:WIDTH];
                        b_reg          <= index_inc[WIDTH-1:0];
                        settle_cnt_reg <= SETTLE_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BIST_FIRST_FAIL_EN
    logic              fail_seen_reg;
    logic [WIDTH-1:0]  fail_a_reg;
    logic [WIDTH-1:0]  fail_b_reg;
    logic [2:0]        fail_flags_reg;

    // Only the first failure of a sweep is kept; later ones are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_seen_reg  <= 1'b0;
            fail_a_reg     <= '0;
            fail_b_reg     <= '0;
            fail_flags_reg <= '0;
        end else if (accept) begin
            fail_seen_reg  <= 1'b0;
            fail_a_reg     <= '0;
            fail_b_reg     <= '0;
            fail_flags_reg <= '0;
        end else if ((state_reg == CHECK) && vec_fail && !fail_seen_reg) begin
            fail_seen_reg  <= 1'b1;
            fail_a_reg     <= a_reg;
            fail_b_reg     <= b_reg;
            fail_flags_reg <= observed;
        end
    end

    assign fail_a     = fail_a_reg;
    assign fail_b     = fail_b_reg;
    assign fail_flags = fail_flags_reg;
`endif

endmodule
